// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the TopLevel program launcher.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        GAP,
        DONE
    } seq_state_t;

    localparam int PROG_P1 = 0;
    localparam int PROG_P2 = 1;
    localparam int PROG_P3 = 2;

    localparam int DEFAULT_TIMEOUT = 50000;

endpackage

// File: rtl/program_sequencer_watchdog.sv
// Saturating run-cycle counter with a hang detector for program_sequencer.
module cycle_watchdog #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expired_o
);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable; the count sticks at all-ones rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == TIMEOUT_V);

endmodule

// File: rtl/program_sequencer.sv
// Launches NUM_PROGS TopLevel programs in order, timing each run and flagging hangs.
// Recorded results stay readable through RdIdx/RdCount until the next Go or reset.
module program_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int  NUM_PROGS = 3,
    parameter int  START_LEN = 1,
    parameter int  GAP_LEN   = 1,
    parameter int  CNT_W     = 16,
    parameter int  TIMEOUT   = DEFAULT_TIMEOUT,
    localparam int SEL_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Go,
    input  logic                 Abort,
    input  logic                 Ack,
    output logic                 Start,
    output logic [SEL_W-1:0]     ProgSel,
    output logic                 Busy,
    output logic                 Done,
    output logic [NUM_PROGS-1:0] TimeoutFlags,
    input  logic [SEL_W-1:0]     RdIdx,
    output logic [CNT_W-1:0]     RdCount
);
    localparam int PH_MAX = (START_LEN > GAP_LEN) ? START_LEN : GAP_LEN;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0]  LAUNCH_LAST = PH_W'(START_LEN - 1);
    localparam logic [PH_W-1:0]  GAP_LAST    = PH_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V   = CNT_W'(TIMEOUT);

    seq_state_t             state_q;
    logic [PH_W-1:0]        phase_q;
    logic [SEL_W-1:0]       sel_q;
    logic                   start_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   armed_q;
    logic [NUM_PROGS-1:0]   flags_q;
    logic [CNT_W-1:0]       counts_q [NUM_PROGS];

    logic                   launchLast;
    logic                   wdEnable;
    logic                   wdClear;
    logic [CNT_W-1:0]       wdCount;
    logic                   wdExpired;

    // The watchdog steps on the final launch cycle so the first RUN cycle reads 1.
    assign launchLast = (state_q == LAUNCH) && (phase_q == LAUNCH_LAST);
    assign wdEnable   = (state_q == RUN) || launchLast;
    assign wdClear    = Abort || !wdEnable;

    cycle_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (Clk),
        .rst_ni    (Reset),
        .clr_i     (wdClear),
        .en_i      (wdEnable),
        .count_o   (wdCount),
        .expired_o (wdExpired)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            sel_q   <= SEL_W'(PROG_P1);
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
            flags_q <= '0;
            for (int i = 0; i < NUM_PROGS; i++) counts_q[i] <= '0;
        end else if (Abort) begin
            state_q <= IDLE;
            phase_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (Go) begin
                        state_q <= LAUNCH;
                        phase_q <= '0;
                        sel_q   <= SEL_W'(PROG_P1);
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        flags_q <= '0;
                        for (int i = 0; i < NUM_PROGS; i++) counts_q[i] <= '0;
                    end
                end
                LAUNCH: begin
                    if (launchLast) begin
                        state_q <= RUN;
                        phase_q <= '0;
                        start_q <= 1'b0;
                        armed_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                // A high Ack only counts once Ack has been seen low in this run.
                RUN: begin
                    if (!Ack) armed_q <= 1'b1;
                    if (Ack && armed_q) begin
                        counts_q[sel_q] <= wdCount;
                        state_q         <= GAP;
                    end else if (wdExpired) begin
                        counts_q[sel_q] <= TIMEOUT_V;
                        flags_q[sel_q]  <= 1'b1;
                        state_q         <= GAP;
                    end
                end
                GAP: begin
                    if (phase_q == GAP_LAST) begin
                        phase_q <= '0;
                        if (sel_q == LAST_SEL) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LAUNCH;
                            sel_q   <= sel_q + 1'b1;
                            start_q <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Start        = start_q;
    assign ProgSel      = sel_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign TimeoutFlags = flags_q;

    always_comb begin
        RdCount = '0;
        if (int'(RdIdx) < NUM_PROGS) RdCount = counts_q[RdIdx];
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: per-program Ack profiles drive a run-level result model.
module tb_program_sequencer;

    localparam int NP      = 3;
    localparam int TMO     = 100;
    localparam int CW      = 16;
    localparam int BUDGET  = 1000;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Go;
    logic          Abort;
    logic          Ack;
    logic          Start;
    logic [1:0]    ProgSel;
    logic          Busy;
    logic          Done;
    logic [NP-1:0] TimeoutFlags;
    logic [1:0]    RdIdx;
    logic [CW-1:0] RdCount;

    int errors = 0;
    int checks = 0;

    // Ack profile per program: high for RUN cycles 1..stale, then high again from rise on (0 = never).
    int stale [NP];
    int rise  [NP];

    int  startRises;
    int  startHigh;
    int  curProg;
    int  runK;
    bit  inRun;
    bit  prevStart;
    bit  reached;

    program_sequencer #(
        .NUM_PROGS (NP),
        .START_LEN (1),
        .GAP_LEN   (1),
        .CNT_W     (CW),
        .TIMEOUT   (TMO)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Go           (Go),
        .Abort        (Abort),
        .Ack          (Ack),
        .Start        (Start),
        .ProgSel      (ProgSel),
        .Busy         (Busy),
        .Done         (Done),
        .TimeoutFlags (TimeoutFlags),
        .RdIdx        (RdIdx),
        .RdCount      (RdCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ackAt(input int s, input int r, input int k);
        return (k <= s) || (r != 0 && k >= r);
    endfunction

    // Result of one run: an Ack only qualifies after a low cycle, and must land by TMO.
    function automatic int expCount(input int s, input int r, output bit timedOut);
        timedOut = 1'b1;
        if (r != 0 && r > s + 1 && r <= TMO) begin
            timedOut = 1'b0;
            return r;
        end
        return TMO;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
        if (Start && !prevStart) begin
            startRises++;
            curProg = (startRises - 1 < NP) ? startRises - 1 : NP - 1;
            inRun   = 1'b0;
            runK    = 0;
        end
        if (!Start && prevStart) begin
            inRun = 1'b1;
            runK  = 1;
        end else if (inRun) begin
            runK++;
        end
        if (Start) startHigh++;
        prevStart = Start;
        if (inRun) Ack = ackAt(stale[curProg], rise[curProg], runK);
    endtask

    task automatic applyStimulus();
        startRises = 0;
        startHigh  = 0;
        curProg    = 0;
        runK       = 0;
        inRun      = 1'b0;
        prevStart  = Start;
        Go = 1'b1;
        tick();
        Go = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic [NP-1:0] expFlags;
        int            expC [NP];
        bit            to;
        expFlags = '0;
        for (int i = 0; i < NP; i++) begin
            expC[i]     = expCount(stale[i], rise[i], to);
            expFlags[i] = to;
        end
        check({tag, "_done"}, Done, 1);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_flags"}, TimeoutFlags, expFlags);
        for (int i = 0; i < NP; i++) begin
            RdIdx = 2'(i);
            #1;
            check($sformatf("%s_count%0d", tag, i), RdCount, expC[i]);
        end
    endtask

    task automatic runSequence(input string tag);
        applyStimulus();
        check({tag, "_doneDrop"}, Done, 0);
        check({tag, "_busyRise"}, Busy, 1);
        for (int n = 0; n < BUDGET && !Done; n++) begin
            if (Start) check({tag, "_progsel"}, ProgSel, curProg);
            tick();
        end
        check({tag, "_startRises"}, startRises, NP);
        check({tag, "_startHigh"}, startHigh, NP);
        checkOutput(tag);
    endtask

    initial begin
        Reset = 1'b0;
        Go    = 1'b0;
        Abort = 1'b0;
        Ack   = 1'b0;
        RdIdx = '0;
        prevStart = 1'b0;
        for (int i = 0; i < NP; i++) begin
            stale[i] = 0;
            rise[i]  = 20;
        end

        #3;
        check("rst_start", Start, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_progsel", ProgSel, 0);
        check("rst_flags", TimeoutFlags, 0);
        check("rst_count", RdCount, 0);
        tick();
        tick();
        Reset = 1'b1;
        tick();

        // Plain sequence: each program acks 20 cycles into its run.
        runSequence("basic");
        RdIdx = 2'd3;
        #1;
        check("rdidx_oob", RdCount, 0);

        // Stale Ack held from P1 into P2's launch must not end P2.
        stale[0] = 0; rise[0] = 20;
        stale[1] = 2; rise[1] = 10;
        stale[2] = 0; rise[2] = 20;
        runSequence("stale");

        // P2 hangs; P3 still launches.
        stale[1] = 0; rise[1] = 0;
        runSequence("timeout");

        // Ack on the exact timeout cycle wins.
        stale[0] = 0; rise[0] = TMO;
        stale[1] = 0; rise[1] = 30;
        runSequence("tie");

        // A stale Ack that never drops can only end by timeout.
        stale[0] = 500; rise[0] = 0;
        runSequence("stuckHigh");

        // Abort in P2 RUN cycle 5.
        stale[0] = 0; rise[0] = 8;
        stale[1] = 0; rise[1] = 0;
        stale[2] = 0; rise[2] = 20;
        applyStimulus();
        reached = 1'b0;
        for (int n = 0; n < BUDGET && !reached; n++) begin
            if (curProg == 1 && inRun && runK == 5) reached = 1'b1;
            else tick();
        end
        check("abort_reached", reached, 1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_start", Start, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_progsel", ProgSel, 1);
        tick();
        tick();
        check("abort_stayIdle", Busy, 0);
        RdIdx = 2'd0;
        #1;
        check("abort_count0", RdCount, 8);
        RdIdx = 2'd1;
        #1;
        check("abort_count1", RdCount, 0);
        rise[1] = 12;
        applyStimulus();
        check("restart_start", Start, 1);
        check("restart_progsel", ProgSel, 0);
        check("restart_flags", TimeoutFlags, 0);
        RdIdx = 2'd0;
        #1;
        check("restart_cleared", RdCount, 0);
        for (int n = 0; n < BUDGET && !Done; n++) tick();
        checkOutput("restart");

        // Randomised Ack timing, including hangs and rises past the timeout.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NP; i++) begin
                stale[i] = $urandom_range(0, 3);
                rise[i]  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(2, 110);
            end
            runSequence($sformatf("rand%0d", t));
        end

        // Reset asserted while P2's Start is high.
        for (int i = 0; i < NP; i++) begin
            stale[i] = 0;
            rise[i]  = 15;
        end
        applyStimulus();
        reached = 1'b0;
        for (int n = 0; n < BUDGET && !reached; n++) begin
            if (curProg == 1 && Start) reached = 1'b1;
            else tick();
        end
        check("midrst_reached", reached, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("midrst_start", Start, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_progsel", ProgSel, 0);
        check("midrst_flags", TimeoutFlags, 0);
        RdIdx = 2'd0;
        #1;
        check("midrst_count0", RdCount, 0);
        Go = 1'b1;
        tick();
        tick();
        check("midrst_goIgnored", Start, 0);
        check("midrst_goIgnoredBusy", Busy, 0);
        Go = 1'b0;
        Reset = 1'b1;
        tick();
        runSequence("recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
